imem_loader: RTL and testbench

//  Writer side of the single-cycle core's instruction fetch: receives a program as a byte stream
//  (valid/ready), assembles little-endian 32-bit words and writes them into instruction memory.

---
 rtl/loader_pkg.sv | 7 +
 rtl/word_assembler.sv | 26 ++
 rtl/imem_loader.sv | 99 +++++++++
 tb/tb_imem_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM states and framing constants for the instruction memory loader
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR} state_t;
  localparam int LEN_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W = $clog2(BYTES_PER_WORD);
endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs a byte stream into little-endian words, flagging when the next byte completes one
module word_assembler
  import loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          load,
  input  logic [7:0]                    byte_in,
  output logic [8*BYTES_PER_WORD-1:0]   word,
  output logic                          word_full
);
  logic [BYTE_IDX_W-1:0] idx;
  // each accepted byte lands in the lane picked by the byte index; a partial word is dropped on clear/reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (load) begin
      word[8*idx +: 8] <= byte_in;
      idx              <= idx + 1'b1;
    end
  assign word_full = idx == BYTE_IDX_W'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory, holding the core in reset until done
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);
  localparam int LEN_W = 8*LEN_BYTES;
  state_t state, state_nx;
  logic [LEN_W-1:0] len, len_full;
  logic [ADDR_W:0] word_cnt;
  logic [8*BYTES_PER_WORD-1:0] word;
  logic xfer, restart, word_full, last_word, len_bad;
  assign xfer      = in_valid && in_ready;
  assign restart   = start && (state == DONE || state == ERR);
  assign len_full  = {in_data, len[7:0]};
  assign len_bad   = len_full == '0 || 32'(len_full) > MAX_WORDS;
  assign last_word = LEN_W'(word_cnt) + LEN_W'(1) == len;
  assign mem_addr  = word_cnt[ADDR_W-1:0];
  assign mem_wdata = DATA_W'(word);
  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (restart),
    .load      (xfer && state == DATA),
    .byte_in   (in_data),
    .word      (word),
    .word_full (word_full)
  );
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next state and state-decoded outputs; in_ready depends on state only
  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    core_reset = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE:   state_nx = LEN_LO;
      LEN_LO: begin
        in_ready = 1'b1;
        if (xfer) state_nx = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (xfer) state_nx = len_bad ? ERR : DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        if (xfer && word_full) state_nx = WRITE;
      end
      WRITE: begin
        mem_we   = 1'b1;
        state_nx = last_word ? DONE : DATA;
      end
      DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
        if (restart) state_nx = LEN_LO;
      end
      ERR: begin
        error = 1'b1;
        if (restart) state_nx = LEN_LO;
      end
      default: state_nx = IDLE;
    endcase
  end
  // length header and word index; a reload restarts both so the next frame begins at address 0
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      len      <= '0;
      word_cnt <= '0;
    end else if (restart) begin
      len      <= '0;
      word_cnt <= '0;
    end else begin
      if (xfer && state == LEN_LO) len[7:0] <= in_data;
      if (xfer && state == LEN_HI) len[15:8] <= in_data;
      if (state == WRITE) word_cnt <= word_cnt + 1'b1;
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for the instruction memory loader
module tb_imem_loader;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, mem_we, core_reset, done, error;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  // cycle counter and write capture
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte_timeout byte=%h in_ready=%b expected 1", b, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int gap_max);
    foreach (f[i]) send_byte(f[i], gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && !error && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done done=%b error=%b expected done=1", done, error);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, core_reset, done, error} !== {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%b we=%b addr=%h wd=%h cr=%b dn=%b er=%b expected 0 0 00 00000000 1 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, core_reset, done, error);
    end
    do_reset();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got %b expected 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL len_lo_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] f[$];
    int t0, base;
    f = {8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_reset();
    t0 = cyc;
    base = wa_q.size();
    send_frame(f, 0);
    checks++;
    if ({mem_we, in_ready, mem_addr, mem_wdata} !== {1'b1, 1'b0, 8'h01, 32'h00100093}) begin
      errors++;
      $display("FAIL basic_write_latency got we=%b rdy=%b addr=%h wd=%h expected 1 0 01 00100093", mem_we, in_ready, mem_addr, mem_wdata);
    end
    wait_done();
    checks++;
    if (cyc - t0 !== 13) begin
      errors++;
      $display("FAIL basic_cycles got %0d expected 13", cyc - t0);
    end
    checks++;
    if ({core_reset, done, in_ready, error} !== 4'b0100) begin
      errors++;
      $display("FAIL basic_done_outputs got cr=%b dn=%b rdy=%b er=%b expected 0 1 0 0", core_reset, done, in_ready, error);
    end
    checks++;
    if (wa_q.size() - base !== 2 || wa_q[base] !== 8'h00 || wd_q[base] !== 32'h00500013 || wa_q[base+1] !== 8'h01 || wd_q[base+1] !== 32'h00100093) begin
      errors++;
      $display("FAIL basic_writes got n=%0d expected 2 writes [0]=00500013 [1]=00100093", wa_q.size() - base);
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] f[$];
    int base;
    f = {8'h00, 8'h00};
    do_reset();
    base = wa_q.size();
    send_frame(f, 0);
    in_valid = 1'b1;
    in_data = 8'hAA;
    repeat (3) @(negedge clk);
    checks++;
    if ({error, in_ready, core_reset, done} !== 4'b1010) begin
      errors++;
      $display("FAIL zero_len_err got er=%b rdy=%b cr=%b dn=%b expected 1 0 1 0", error, in_ready, core_reset, done);
    end
    checks++;
    if (wa_q.size() !== base) begin
      errors++;
      $display("FAIL zero_len_no_write got %0d writes expected 0", wa_q.size() - base);
    end
    in_valid = 1'b0;
    pulse_start();
    checks++;
    if ({error, in_ready, core_reset} !== 3'b011) begin
      errors++;
      $display("FAIL err_restart got er=%b rdy=%b cr=%b expected 0 1 1", error, in_ready, core_reset);
    end
  endtask

  task automatic test_len_bounds();
    logic [7:0] f[$];
    int base;
    f = {8'h01, 8'h01};
    do_reset();
    send_frame(f, 0);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL len_257_err got %b expected 1", error);
    end
    pulse_start();
    f = {8'h00, 8'h01};
    for (int i = 0; i < 256; i++) f = {f, 8'(i), 8'h11, 8'h22, 8'h33};
    base = wa_q.size();
    send_frame(f, 0);
    wait_done();
    checks++;
    if (wa_q.size() - base !== 256) begin
      errors++;
      $display("FAIL len_256_count got %0d expected 256", wa_q.size() - base);
    end else begin
      checks++;
      if (wa_q[base] !== 8'h00 || wd_q[base] !== 32'h33221100 || wa_q[base+255] !== 8'hFF || wd_q[base+255] !== 32'h332211FF) begin
        errors++;
        $display("FAIL len_256_ends got first %h:%h last %h:%h expected 00:33221100 ff:332211ff",
                 wa_q[base], wd_q[base], wa_q[base+255], wd_q[base+255]);
      end
    end
  endtask

  task automatic test_gapped();
    logic [7:0] f[$];
    int base;
    f = {8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_reset();
    base = wa_q.size();
    foreach (f[i]) begin
      if (i == 6) begin
        in_valid = 1'b1;
        in_data = f[i];
        checks++;
        if ({mem_we, in_ready} !== 2'b10) begin
          errors++;
          $display("FAIL hold_in_write got we=%b rdy=%b expected 1 0", mem_we, in_ready);
        end
      end
      send_byte(f[i], i == 6 ? 0 : int'($urandom_range(0, 3)));
    end
    in_valid = 1'b0;
    wait_done();
    checks++;
    if (wa_q.size() - base !== 2 || wa_q[base] !== 8'h00 || wd_q[base] !== 32'h00500013 || wa_q[base+1] !== 8'h01 || wd_q[base+1] !== 32'h00100093) begin
      errors++;
      $display("FAIL gapped_writes got n=%0d expected 2 writes [0]=00500013 [1]=00100093", wa_q.size() - base);
    end
  endtask

  task automatic test_midreset();
    logic [7:0] f[$];
    int base;
    f = {8'h02, 8'h00, 8'h13, 8'h00};
    do_reset();
    send_frame(f, 0);
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, core_reset, done, error} !== {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_values got rdy=%b we=%b addr=%h wd=%h cr=%b dn=%b er=%b expected 0 0 00 00000000 1 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, core_reset, done, error);
    end
    f = {8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_reset();
    base = wa_q.size();
    send_frame(f, 0);
    wait_done();
    checks++;
    if (wa_q.size() - base !== 2 || wa_q[base] !== 8'h00 || wd_q[base] !== 32'h00500013 || wa_q[base+1] !== 8'h01 || wd_q[base+1] !== 32'h00100093) begin
      errors++;
      $display("FAIL midreset_reload got n=%0d expected 2 writes [0]=00500013 [1]=00100093", wa_q.size() - base);
    end
  endtask

  task automatic test_reload();
    logic [7:0] f[$];
    int base;
    f = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    pulse_start();
    checks++;
    if ({core_reset, done, in_ready} !== 3'b101) begin
      errors++;
      $display("FAIL reload_start got cr=%b dn=%b rdy=%b expected 1 0 1", core_reset, done, in_ready);
    end
    base = wa_q.size();
    send_frame(f, 0);
    wait_done();
    checks++;
    if (wa_q.size() - base !== 1 || wa_q[base] !== 8'h00 || wd_q[base] !== 32'hDEADBEEF || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL reload_write got n=%0d cr=%b expected 1 write [0]=deadbeef cr=0", wa_q.size() - base, core_reset);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_len_bounds();
    test_gapped();
    test_midreset();
    test_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
